// File: rtl/fp_add_issuer.sv
// Floating-point add issuer: accepts an operand pair, reports exponent
// ordering/difference, bypasses the adder when an operand is zero, otherwise
// pulses Go to the adder controller and captures its sum, with a watchdog
// that latches a sticky Timeout error.
module fp_add_issuer #(
    parameter int EXPBITS      = 8,
    parameter int MANTISSABITS = 23,
    parameter int TIMEOUT      = 64,
    localparam int W           = 1 + EXPBITS + MANTISSABITS
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               InValid,
    output logic               InReady,
    input  logic [W-1:0]       InA,
    input  logic [W-1:0]       InB,
    output logic               ExpSet,
    output logic [EXPBITS-1:0] ExpDiff,
    output logic               Go,
    input  logic               Result,
    input  logic [W-1:0]       SumIn,
    output logic               OutValid,
    input  logic               OutReady,
    output logic [W-1:0]       OutSum,
    output logic               Timeout
);

    // Counter must be able to represent TIMEOUT+1 so the limit compare never wraps.
    localparam int CW = $clog2(TIMEOUT + 2);
    localparam logic [CW-1:0] CNT_LIM = CW'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_GO, S_DRAIN, S_WAIT, S_OUT, S_ERR
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  sum_q, sum_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tmo_q, tmo_d;

    logic [EXPBITS-1:0] exp_a, exp_b;
    logic               a_ge_b;
    logic               a_zero, b_zero;
    logic [CW-1:0]      cnt_next;

    assign exp_a    = a_q[W-2 -: EXPBITS];
    assign exp_b    = b_q[W-2 -: EXPBITS];
    assign a_ge_b   = (exp_a >= exp_b);
    // Zero means exponent and mantissa both clear; the sign bit is ignored.
    assign a_zero   = (a_q[W-2:0] == '0);
    assign b_zero   = (b_q[W-2:0] == '0);
    assign cnt_next = cnt_q + 1'b1;

    // Exponent info only reflects a live operand pair; operand registers are
    // frozen outside IDLE, so these stay stable until the pair retires.
    assign ExpSet   = (state_q != S_IDLE) && a_ge_b;
    assign ExpDiff  = (state_q == S_IDLE) ? '0 : (a_ge_b ? (exp_a - exp_b) : (exp_b - exp_a));
    assign InReady  = (state_q == S_IDLE);
    assign Go       = (state_q == S_GO);
    assign OutValid = (state_q == S_OUT);
    assign OutSum   = sum_q;
    assign Timeout  = tmo_q;

    // Next-state, operand capture, sum capture and watchdog counting.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (InValid) begin
                    a_d     = InA;
                    b_d     = InB;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (b_zero) begin
                    sum_d   = a_q;
                    state_d = S_OUT;
                end else if (a_zero) begin
                    sum_d   = b_q;
                    state_d = S_OUT;
                end else begin
                    state_d = S_GO;
                end
            end
            S_GO: begin
                // Counter holds 0 during GO, so it equals cycles elapsed since Go.
                cnt_d   = cnt_next;
                state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (cnt_next >= CNT_LIM) begin
                    tmo_d   = 1'b1;
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_next;
                    if (!Result) state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (Result) begin
                    sum_d   = SumIn;
                    state_d = S_OUT;
                end else if (cnt_next >= CNT_LIM) begin
                    tmo_d   = 1'b1;
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_next;
                end
            end
            S_OUT: begin
                if (OutReady) state_d = S_IDLE;
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
        end
    end

endmodule

// File: doc/fp_add_issuer.md
FP_ADD_ISSUER -- requirements
Module: fp_add_issuer

Interface
REQ-001 Parameter EXPBITS, default 8, exponent field width.
REQ-002 Parameter MANTISSABITS, default 23, stored mantissa width.
REQ-003 Parameter TIMEOUT, default 64, max cycles allowed for the adder to return Result.
REQ-004 W = 1+EXPBITS+MANTISSABITS (sign, exponent, mantissa packed MSB to LSB).
REQ-005 Clock  input  1  rising-edge clock.
REQ-006 Reset  input  1  reset, synchronous, active-high.
REQ-007 InValid  input  1  operand pair valid.
REQ-008 InReady  output  1  issuer accepts operand pair.
REQ-009 InA, InB  input  W each  operands.
REQ-010 ExpSet  output  1  1 when exponent(A) >= exponent(B).
REQ-011 ExpDiff  output  EXPBITS  |exponent(A) - exponent(B)|.
REQ-012 Go  output  1  one-cycle start pulse to the adder controller.
REQ-013 Result  input  1  adder done level; set when done, cleared by controller after Go.
REQ-014 SumIn  input  W  adder sum, valid while Result=1.
REQ-015 OutValid  output  1  sum available.
REQ-016 OutReady  input  1  downstream accepts sum.
REQ-017 OutSum  output  W  captured sum.
REQ-018 Timeout  output  1  sticky error flag, cleared only by Reset.

Function
REQ-019 States: IDLE, LOAD, GO, DRAIN, WAIT, OUT, ERR.
REQ-020 IDLE: InReady=1; InValid=1 captures InA/InB into operand registers -> LOAD.
REQ-021 LOAD: ExpSet/ExpDiff are computed from the registered operands and are held stable from LOAD until the state returns to IDLE.
REQ-022 LOAD, either operand has exponent=0 and mantissa=0 (zero): OutSum = other operand (A if both zero), bypass adder -> OUT; else -> GO.
REQ-023 GO: Go=1 for exactly this one cycle -> DRAIN; Go=0 in every other state.
REQ-024 DRAIN: ignore Result until sampled 0 (stale Result from previous op), then -> WAIT.
REQ-025 WAIT: Result=1 captures SumIn into OutSum -> OUT.
REQ-026 Cycle counter starts at 0 in GO and increments each cycle in DRAIN and WAIT; reaching TIMEOUT without capture -> ERR, Timeout<=1.
REQ-027 OUT: OutValid=1, OutSum stable; OutValid&&OutReady -> IDLE; no new operand accepted while in OUT.
REQ-028 ERR: OutValid=0, InReady=0, Go=0; exits only via Reset.
REQ-029 InReady=1 only in IDLE; upstream handshake occurs only on InValid&&InReady.
REQ-030 Throughput: non-bypass op accepted at cycle t gives Go at t+2; bypass gives OutValid at t+2.
REQ-031 ExpDiff is the full-width unsigned difference; no saturation (adder controller clamps).

Reset
REQ-032 Reset has priority over all inputs; takes effect on the next rising edge, including mid-operation.
REQ-033 Reset values: state IDLE, InReady=1 after reset deasserts, Go=0, OutValid=0, OutSum=0, ExpSet=0, ExpDiff=0, Timeout=0, counter=0.
REQ-034 Operation in progress at Reset is discarded; a later Result=1 is ignored until a new Go.

Verification
REQ-035 A=0x3F800000, B=0x40000000 -> ExpSet=0, ExpDiff=1, one Go pulse; Result=1 with SumIn=0x40400000 -> OutSum=0x40400000, OutValid=1.
REQ-036 A=0x40000000, B=0x40000000 -> ExpSet=1, ExpDiff=0; Result held 1 from prior op for 2 cycles after Go -> not captured until 0 then 1 seen.
REQ-037 A=0x00000000, B=0xC0A00000 -> no Go, OutSum=0xC0A00000 at t+2.
REQ-038 Result never asserted after Go -> Timeout=1 at TIMEOUT=64 cycles after GO, InReady=0, OutValid=0 until Reset.
REQ-039 OutReady=0 for 10 cycles in OUT -> OutValid, OutSum stable, InReady=0; OutReady=1 -> IDLE next cycle.
REQ-040 Reset asserted in WAIT -> IDLE, all outputs at reset values; subsequent Result=1 produces no OutValid.
